// File: rtl/sdram_read_router.sv
// sdram_read_router: routes SDRAM read returns to Port0 or PortV using an
// in-order tag FIFO written at issue time. Address consistency and protocol
// faults are reported through sticky error flags.
module sdram_read_router #(
   parameter int TAG_DEPTH = 64,
   parameter int ADDR_W    = 25,
   parameter int DATA_W    = 16,
   parameter int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic                     issue_port,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready,
   input  logic                     read_valid,
   input  logic [ADDR_W-1:0]        read_addr,
   input  logic [DATA_W-1:0]        read_data,
   output logic                     port0_valid,
   output logic [ADDR_W+DATA_W-1:0] port0_data,
   output logic                     portV_valid,
   output logic [9:0]               portV_data,
   output logic [CNT_W-1:0]         outstanding,
   output logic                     err_overflow,
   output logic                     err_orphan,
   output logic                     err_mismatch
);

   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

   // Tag storage: port bit and address per outstanding read
   logic              r_tag_port [TAG_DEPTH];
   logic [ADDR_W-1:0] r_tag_addr [TAG_DEPTH];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic              w_head_port;
   logic [ADDR_W-1:0] w_head_addr;

   // Readiness depends only on the registered count, never on a same-cycle pop
   assign issue_ready = (r_count < DEPTH_C);
   assign w_empty     = (r_count == '0);
   assign w_push      = issue_valid & issue_ready;
   // An empty FIFO cannot see a same-cycle push, so such a return is an orphan
   assign w_pop       = read_valid & ~w_empty;
   assign w_head_port = r_tag_port[r_rd_ptr];
   assign w_head_addr = r_tag_addr[r_rd_ptr];
   assign outstanding = r_count;

   // Tag memory write on accepted issue (storage needs no reset; validity is tracked by r_count)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tag_port[r_wr_ptr] <= issue_port;
         r_tag_addr[r_wr_ptr] <= issue_addr;
      end
   end

   // Pointers wrap naturally mod TAG_DEPTH; count distinguishes full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered routing: exactly one cycle from return to output pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         port0_valid <= 1'b0;
         portV_valid <= 1'b0;
         port0_data  <= '0;
         portV_data  <= '0;
      end else begin
         port0_valid <= w_pop & ~w_head_port;
         portV_valid <= w_pop &  w_head_port;
         if (w_pop && !w_head_port) port0_data <= {read_addr, read_data};
         if (w_pop &&  w_head_port) portV_data <= read_data[9:0];
      end
   end

   // Sticky protocol fault flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         err_overflow <= 1'b0;
         err_orphan   <= 1'b0;
         err_mismatch <= 1'b0;
      end else begin
         if (issue_valid && !issue_ready)        err_overflow <= 1'b1;
         if (read_valid && w_empty)              err_orphan   <= 1'b1;
         if (w_pop && (read_addr != w_head_addr)) err_mismatch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_read_router.sv
// tb_sdram_read_router: directed vectors with hand-computed expectations.
module tb_sdram_read_router;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_port = 1'b0;
   logic [24:0] issue_addr = '0;
   logic        issue_ready;
   logic        read_valid = 1'b0;
   logic [24:0] read_addr = '0;
   logic [15:0] read_data = '0;
   logic        port0_valid;
   logic [40:0] port0_data;
   logic        portV_valid;
   logic [9:0]  portV_data;
   logic [6:0]  outstanding;
   logic        err_overflow;
   logic        err_orphan;
   logic        err_mismatch;

   int n_cmp = 0;
   int n_bad = 0;

   sdram_read_router dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_port(issue_port), .issue_addr(issue_addr),
      .issue_ready(issue_ready),
      .read_valid(read_valid), .read_addr(read_addr), .read_data(read_data),
      .port0_valid(port0_valid), .port0_data(port0_data),
      .portV_valid(portV_valid), .portV_data(portV_data),
      .outstanding(outstanding),
      .err_overflow(err_overflow), .err_orphan(err_orphan), .err_mismatch(err_mismatch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample #1 after the edge
   task automatic step(input logic iv, input logic ip, input logic [24:0] ia,
                       input logic rv, input logic [24:0] ra, input logic [15:0] rd);
      issue_valid = iv; issue_port = ip; issue_addr = ia;
      read_valid  = rv; read_addr  = ra; read_data  = rd;
      @(posedge clk); #1;
      issue_valid = 1'b0; read_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_out",   64'(outstanding), 64'd0);
      check("rst_ready", 64'(issue_ready), 64'd1);
      check("rst_vld",   64'({port0_valid, portV_valid}), 64'd0);
      check("rst_data",  64'({port0_data, portV_data}), 64'd0);
      check("rst_err",   64'({err_overflow, err_orphan, err_mismatch}), 64'd0);

      // Basic routing
      step(1, 0, 25'h100, 0, 0, 0);
      step(1, 1, 25'h200, 0, 0, 0);
      step(1, 0, 25'h101, 0, 0, 0);
      check("b_out3", 64'(outstanding), 64'd3);
      step(0, 0, 0, 1, 25'h100, 16'hAAAA);
      check("b1_vld",  64'({port0_valid, portV_valid}), 64'b10);
      check("b1_data", 64'(port0_data), {23'd0, 25'h100, 16'hAAAA});
      check("b1_out",  64'(outstanding), 64'd2);
      step(0, 0, 0, 1, 25'h200, 16'h03FF);
      check("b2_vld",  64'({port0_valid, portV_valid}), 64'b01);
      check("b2_data", 64'(portV_data), 64'h3FF);
      check("b2_hold", 64'(port0_data), {23'd0, 25'h100, 16'hAAAA});
      check("b2_out",  64'(outstanding), 64'd1);
      step(0, 0, 0, 1, 25'h101, 16'h1234);
      check("b3_vld",  64'({port0_valid, portV_valid}), 64'b10);
      check("b3_data", 64'(port0_data), {23'd0, 25'h101, 16'h1234});
      check("b3_out",  64'(outstanding), 64'd0);
      step(0, 0, 0, 0, 0, 0);
      check("b_idle",  64'({port0_valid, portV_valid}), 64'd0);
      check("b_err",   64'({err_overflow, err_orphan, err_mismatch}), 64'd0);

      // Fill and overflow with simultaneous pop
      do_reset();
      for (int i = 0; i < 64; i++) step(1, 1, 25'h300 + 25'(i), 0, 0, 0);
      check("f_out",   64'(outstanding), 64'd64);
      check("f_ready", 64'(issue_ready), 64'd0);
      check("f_ovf0",  64'(err_overflow), 64'd0);
      step(1, 0, 25'h999, 1, 25'h300, 16'h0ABC);
      check("o_ovf",   64'(err_overflow), 64'd1);
      check("o_out",   64'(outstanding), 64'd63);
      check("o_ready", 64'(issue_ready), 64'd1);
      check("o_vld",   64'({port0_valid, portV_valid}), 64'b01);
      check("o_data",  64'(portV_data), 64'h2BC);
      check("o_mis",   64'(err_mismatch), 64'd0);

      // Orphan return with same-cycle issue
      do_reset();
      step(1, 0, 25'h7, 1, 25'h7, 16'h5555);
      check("r_vld",  64'({port0_valid, portV_valid}), 64'd0);
      check("r_orph", 64'(err_orphan), 64'd1);
      check("r_out",  64'(outstanding), 64'd1);

      // Address mismatch still routes per tag
      do_reset();
      step(1, 1, 25'h50, 0, 0, 0);
      step(0, 0, 0, 1, 25'h51, 16'h0155);
      check("m_vld",  64'({port0_valid, portV_valid}), 64'b01);
      check("m_data", 64'(portV_data), 64'h155);
      check("m_mis",  64'(err_mismatch), 64'd1);
      check("m_out",  64'(outstanding), 64'd0);

      // 200 pairs, 3 in flight, alternating ports, crossing pointer wrap
      do_reset();
      for (int c = 0; c < 203; c++) begin
         automatic int k = c - 3;
         automatic logic [24:0] ra = 25'h1000 + 25'(k);
         automatic logic [15:0] rd = 16'(k * 7 + 16'h100);
         step(c < 200, c[0], 25'h1000 + 25'(c), c >= 3, ra, rd);
         if (c >= 3) begin
            if (k[0]) begin
               check("s_vldV", 64'({port0_valid, portV_valid}), 64'b01);
               check("s_datV", 64'(portV_data), 64'(rd[9:0]));
            end else begin
               check("s_vld0", 64'({port0_valid, portV_valid}), 64'b10);
               check("s_dat0", 64'(port0_data), {23'd0, ra, rd});
            end
         end
      end
      check("s_out", 64'(outstanding), 64'd0);
      check("s_err", 64'({err_overflow, err_orphan, err_mismatch}), 64'd0);

      // Reset mid-stream with reads outstanding
      do_reset();
      for (int i = 0; i < 5; i++) step(1, i[0], 25'h40 + 25'(i), 0, 0, 0);
      check("x_out5", 64'(outstanding), 64'd5);
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      check("x_out0", 64'(outstanding), 64'd0);
      step(0, 0, 0, 1, 25'h40, 16'h1111);
      check("x_vld1", 64'({port0_valid, portV_valid}), 64'd0);
      step(0, 0, 0, 1, 25'h41, 16'h2222);
      check("x_vld2", 64'({port0_valid, portV_valid}), 64'd0);
      check("x_out",  64'(outstanding), 64'd0);
      check("x_orph", 64'(err_orphan), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
